// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter: shares one single-port RGB565 frame-buffer RAM between the
// LCD scan-out reader and the drawing-engine writer, with read priority and a
// bounded read streak so a pending write always makes progress.
//
// Ports:
//   clk, rst_in              clock; asynchronous active-high reset
//   rd_req/rd_x/rd_y         read request (level, held until rd_gnt)
//   rd_gnt                   read accepted this cycle (combinational)
//   rd_valid/rd_data         read result, fixed 3-cycle latency
//   wr_valid/wr_x/wr_y/      write request (valid/ready)
//   wr_data/wr_ready
//   ram_en/ram_we/ram_addr/  registered RAM command, address = y*LCD_W+x
//   ram_wdata
//   ram_rdata                RAM read data, valid 1 cycle after ram_en
//   drop_cnt                 saturating count of out-of-range accesses
//
// Optional feature, macro LCD_FB_CLEAR_EN: adds clear_start, clear_color and
// clear_busy plus a CLEAR state that fills the whole screen with one colour.
module lcd_fb_arbiter #(
    parameter int LCD_W         = 132,
    parameter int LCD_H         = 162,
    parameter int ADDR_W        = 15,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_in,
`ifdef LCD_FB_CLEAR_EN
    input  logic              clear_start,
    input  logic [15:0]       clear_color,
    output logic              clear_busy,
`endif
    input  logic              rd_req,
    input  logic [7:0]        rd_x,
    input  logic [7:0]        rd_y,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    input  logic              wr_valid,
    input  logic [7:0]        wr_x,
    input  logic [7:0]        wr_y,
    input  logic [15:0]       wr_data,
    output logic              wr_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic [15:0]       drop_cnt
);

    localparam int NPIX = LCD_W * LCD_H;
    localparam int SW   = $clog2(MAX_RD_STREAK + 1);

`ifdef LCD_FB_CLEAR_EN
    typedef enum logic {ST_ARB, ST_CLEAR} state_t;
`else
    typedef enum logic {ST_ARB} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_streak;

    logic              r_p1_vld;
    logic              r_p1_oor;
    logic              r_p2_vld;
    logic              r_p2_oor;

    logic              w_rd_in;
    logic              w_wr_in;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    logic              w_wr_pend;
    logic              w_wr_ok;
    logic [ADDR_W-1:0] w_wr_sel_a;
    logic [15:0]       w_wr_sel_d;
    logic              w_rd_gnt;
    logic              w_wr_gnt;
    logic              w_ram_go;
    logic              w_oor;

`ifdef LCD_FB_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_addr;
    logic [15:0]       r_clr_color;
`endif

    assign w_rd_in   = (32'(rd_x) < LCD_W) && (32'(rd_y) < LCD_H);
    assign w_wr_in   = (32'(wr_x) < LCD_W) && (32'(wr_y) < LCD_H);
    assign w_rd_addr = ADDR_W'(32'(rd_y) * LCD_W + 32'(rd_x));
    assign w_wr_addr = ADDR_W'(32'(wr_y) * LCD_W + 32'(wr_x));

    always_comb begin
        w_state_nxt = r_state;
        w_wr_pend   = wr_valid;
        w_wr_ok     = w_wr_in;
        w_wr_sel_a  = w_wr_addr;
        w_wr_sel_d  = wr_data;
`ifdef LCD_FB_CLEAR_EN
        // The clear writer owns the write slot and always has data pending.
        if (r_state == ST_CLEAR) begin
            w_wr_pend  = 1'b1;
            w_wr_ok    = 1'b1;
            w_wr_sel_a = r_clr_addr;
            w_wr_sel_d = r_clr_color;
        end
`endif
        // Reads win unless a write has waited through a full streak.
        w_rd_gnt = !rst_in && rd_req &&
                   (!w_wr_pend || (r_streak < SW'(MAX_RD_STREAK)));
        w_wr_gnt = !rst_in && !w_rd_gnt && w_wr_pend;
`ifdef LCD_FB_CLEAR_EN
        unique case (r_state)
            ST_ARB: begin
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_wr_gnt && (r_clr_addr == ADDR_W'(NPIX - 1))) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
`endif
    end

    assign rd_gnt   = w_rd_gnt;
    assign wr_ready = w_wr_gnt && (r_state == ST_ARB);
    assign w_ram_go = (w_rd_gnt && w_rd_in) || (w_wr_gnt && w_wr_ok);
    assign w_oor    = (w_rd_gnt && !w_rd_in) || (w_wr_gnt && !w_wr_ok);

`ifdef LCD_FB_CLEAR_EN
    assign clear_busy = (r_state == ST_CLEAR);
`endif

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= ST_ARB;
            r_streak  <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            r_p1_vld  <= 1'b0;
            r_p1_oor  <= 1'b0;
            r_p2_vld  <= 1'b0;
            r_p2_oor  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_wr_gnt || !w_wr_pend) begin
                r_streak <= '0;
            end else if (w_rd_gnt) begin
                r_streak <= r_streak + SW'(1);
            end

            ram_en <= w_ram_go;
            ram_we <= w_wr_gnt && w_wr_ok;
            if (w_ram_go) begin
                ram_addr <= w_rd_gnt ? w_rd_addr : w_wr_sel_a;
                if (!w_rd_gnt) begin
                    ram_wdata <= w_wr_sel_d;
                end
            end

            // Read pipeline: out-of-range reads still flow, returning zero.
            r_p1_vld <= w_rd_gnt;
            r_p1_oor <= !w_rd_in;
            r_p2_vld <= r_p1_vld;
            r_p2_oor <= r_p1_oor;
            rd_valid <= r_p2_vld;
            if (r_p2_vld) begin
                rd_data <= r_p2_oor ? 16'h0000 : ram_rdata;
            end

            if (w_oor && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

`ifdef LCD_FB_CLEAR_EN
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_clr_addr  <= '0;
            r_clr_color <= '0;
        end else if ((r_state == ST_ARB) && clear_start) begin
            r_clr_addr  <= '0;
            r_clr_color <= clear_color;
        end else if ((r_state == ST_CLEAR) && w_wr_gnt) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// tb_lcd_fb_arbiter: directed and randomized checks of lcd_fb_arbiter against
// a transaction-level model (grant rule, shadow frame buffer, result queue).
module tb_lcd_fb_arbiter;

    localparam int W = 132;
    localparam int H = 162;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rd_req;
    logic [7:0]  rd_x, rd_y;
    logic        rd_gnt, rd_valid;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [7:0]  wr_x, wr_y;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [15:0] drop_cnt;
`ifdef LCD_FB_CLEAR_EN
    logic        clear_start;
    logic [15:0] clear_color;
    logic        clear_busy;
`endif

    lcd_fb_arbiter dut (
        .clk(clk), .rst_in(rst_in),
`ifdef LCD_FB_CLEAR_EN
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy),
`endif
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input int a);
        return 16'(a) ^ 16'h5A3C;
    endfunction

    // Frame RAM: bit 16 marks a written word; unwritten words read dflt().
    logic [16:0] mem [N];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= {1'b1, ram_wdata};
            else ram_rdata <= (mem[ram_addr][16] === 1'b1) ?
                              mem[ram_addr][15:0] : dflt(int'(ram_addr));
        end
    end

    typedef struct { int due; logic [15:0] d; } rexp_t;
    rexp_t       rq[$];
    logic [15:0] shadow [N];
    int          total, bad, cyc, m_streak, m_drop;
    logic        e_en, e_we;
    int          e_addr;
    logic [15:0] e_wd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rq_i, input logic [7:0] rx, ry,
                        input logic wv, input logic [7:0] wx, wy,
                        input logic [15:0] wd, output bit gr, output bit gw);
        bit ev, rin, win;
        int ra, wa;
        @(negedge clk);
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rd_valid", rd_valid, ev);
        if (ev) begin
            chk("rd_data", rd_data, rq[0].d);
            void'(rq.pop_front());
        end
        chk("ram_en", ram_en, e_en);
        chk("ram_we", ram_we, e_we);
        if (e_en) chk("ram_addr", ram_addr, e_addr);
        if (e_we) chk("ram_wdata", ram_wdata, e_wd);
        chk("drop_cnt", drop_cnt, m_drop);
        rd_req = rq_i; rd_x = rx; rd_y = ry;
        wr_valid = wv; wr_x = wx; wr_y = wy; wr_data = wd;
        #1;
        gr = rq_i && (!wv || m_streak < 4);
        gw = !gr && wv;
        chk("rd_gnt", rd_gnt, gr);
        chk("wr_ready", wr_ready, gw);
        rin = (rx < W) && (ry < H);
        win = (wx < W) && (wy < H);
        ra = ry * W + rx;
        wa = wy * W + wx;
        e_en = (gr && rin) || (gw && win);
        e_we = gw && win;
        if (gr && rin) e_addr = ra;
        if (gw && win) begin e_addr = wa; e_wd = wd; end
        if (gr) rq.push_back('{cyc + 3, rin ? shadow[ra] : 16'h0000});
        if (gw && win) shadow[wa] = wd;
        if (((gr && !rin) || (gw && !win)) && m_drop < 65535) m_drop++;
        if (gw || !wv) m_streak = 0;
        else if (gr) m_streak++;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a, b;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    initial begin
        bit gr, gw, pr, pw;
        logic [7:0] px, py, qx, qy;
        logic [15:0] qd;
        int k;
        total = 0; bad = 0; cyc = 0; m_streak = 0; m_drop = 0;
        e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
        for (int i = 0; i < N; i++) shadow[i] = dflt(i);
        rst_in = 1; rd_req = 0; rd_x = 0; rd_y = 0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = 0;
`ifdef LCD_FB_CLEAR_EN
        clear_start = 0; clear_color = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_in = 0;

        // Write (3,2) -> address 267.
        step(0, 0, 0, 1, 3, 2, 16'hF800, gr, gw);
        chk("t1_wr_ready", wr_ready, 1);
        idle(1);
        chk("t1_ram_en", ram_en, 1);
        chk("t1_ram_we", ram_we, 1);
        chk("t1_ram_addr", ram_addr, 267);
        chk("t1_ram_wdata", ram_wdata, 16'hF800);

        // Last pixel: address 21383, latency 3.
        step(0, 0, 0, 1, 131, 161, 16'h1234, gr, gw);
        step(1, 131, 161, 0, 0, 0, 0, gr, gw);
        idle(1);
        chk("t2_ram_addr", ram_addr, 21383);
        idle(1);
        chk("t2_early", rd_valid, 0);
        idle(1);
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_rd_data", rd_data, 16'h1234);

        // Out-of-range write and read.
        step(0, 0, 0, 1, 132, 0, 16'hBEEF, gr, gw);
        chk("t4_drop0", drop_cnt, 0);
        step(1, 0, 162, 0, 0, 0, 0, gr, gw);
        chk("t4_en_w", ram_en, 0);
        idle(1);
        chk("t4_en_r", ram_en, 0);
        chk("t4_drop2", drop_cnt, 2);
        idle(2);
        chk("t4_rd_valid", rd_valid, 1);
        chk("t4_rd_data", rd_data, 0);

        // Both requesters held: R,R,R,R,W repeating.
        for (int i = 0; i < 10; i++) begin
            step(1, 5, 5, 1, 6, 6, 16'h1357, gr, gw);
            chk("t3_pat", rd_gnt, (i % 5) != 4);
            if (i >= 3) chk("t3_rv", rd_valid, ((i - 3) % 5) != 4);
        end
        idle(4);

        // Reset one cycle after a read grant discards the read.
        step(1, 3, 2, 0, 0, 0, 0, gr, gw);
        @(negedge clk);
        rd_req = 0;
        rst_in = 1;
        #1;
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_ram_en", ram_en, 0);
        chk("t6_ram_addr", ram_addr, 0);
        chk("t6_ram_wdata", ram_wdata, 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_rd_gnt", rd_gnt, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_hold", rd_valid, 0);
        end
        rst_in = 0;
        rq.delete();
        m_streak = 0; m_drop = 0; e_en = 0; e_we = 0;
        idle(3);
        step(1, 3, 2, 0, 0, 0, 0, gr, gw);
        idle(2);
        chk("t6_early", rd_valid, 0);
        idle(1);
        chk("t6_rd_valid", rd_valid, 1);
        chk("t6_rd_data", rd_data, 16'hF800);
        idle(2);

`ifdef LCD_FB_CLEAR_EN
        @(negedge clk);
        clear_color = 16'h07E0;
        clear_start = 1;
        #1;
        chk("clr_busy0", clear_busy, 0);
        @(negedge clk);
        clear_start = 0;
        wr_valid = 1; wr_x = 1; wr_y = 1; wr_data = 16'hFFFF;
        #1;
        chk("clr_busy1", clear_busy, 1);
        chk("clr_wr_ready", wr_ready, 0);
        k = 0;
        for (int t = 0; t < N + 100 && k < N; t++) begin
            @(negedge clk);
            #1;
            if (ram_en) begin
                chk("clr_we", ram_we, 1);
                chk("clr_addr", ram_addr, k);
                chk("clr_data", ram_wdata, 16'h07E0);
                chk("clr_busy", clear_busy, k < N - 1);
                k++;
            end
            if (k == N) wr_valid = 0;
            else chk("clr_wr_block", wr_ready, 0);
        end
        chk("clr_count", k, N);
        chk("clr_done", clear_busy, 0);
        for (int i = 0; i < N; i++) shadow[i] = 16'h07E0;
        m_streak = 0; e_en = 0; e_we = 0;
`endif

        // Randomized traffic with held requests.
        pr = 0; pw = 0;
        px = 0; py = 0; qx = 0; qy = 0; qd = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pr && ($urandom % 3 != 0)) begin
                pr = 1;
                px = ($urandom % 6 == 0) ? 8'($urandom_range(132, 140))
                                         : 8'($urandom_range(0, 15));
                py = ($urandom % 6 == 0) ? 8'($urandom_range(162, 170))
                                         : 8'($urandom_range(0, 7));
            end
            if (!pw && ($urandom % 2 == 0)) begin
                pw = 1;
                qx = ($urandom % 8 == 0) ? 8'($urandom_range(132, 255))
                                         : 8'($urandom_range(0, 15));
                qy = 8'($urandom_range(0, 7));
                qd = 16'($urandom);
            end
            step(pr, px, py, pw, qx, qy, qd, gr, gw);
            if (gr) pr = 0;
            if (gw) pw = 0;
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_fb_arbiter.md
Name: lcd_fb_arbiter

Overview:
- Shares one single-port RGB565 frame-buffer RAM between two requesters: the LCD scan-out reader (SPI LCD driver, x/y pixel reads) and the drawing engine writer.
- Converts (x,y) to a linear address and gives reads priority. A bounded read streak guarantees the writer forward progress.
- Fixed read latency, plus bounds checking and a drop counter.
- Sits between the frame RAM and both the LCD driver and the drawing logic.

Parameters:
- LCD_W, 132, screen width in pixels
- LCD_H, 162, screen height in pixels
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= LCD_W*LCD_H
- MAX_RD_STREAK, 4, max consecutive read grants while a write is pending

Ports:
- clk  in  1  clock
- rst_in  in  1  reset: asynchronous, active-high
- rd_req  in  1  read request, level; held until rd_gnt
- rd_x  in  8  read pixel column
- rd_y  in  8  read pixel row
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  read data valid pulse
- rd_data  out  16  read pixel RGB565
- wr_valid  in  1  write request, valid/ready
- wr_x  in  8  write column
- wr_y  in  8  write row
- wr_data  in  16  write pixel
- wr_ready  out  1  write accepted this cycle (combinational)
- ram_en  out  1  RAM access enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  linear address y*LCD_W+x (registered)
- ram_wdata  out  16  RAM write data (registered)
- ram_rdata  in  16  RAM read data, valid 1 cycle after ram_en
- drop_cnt  out  16  saturating count of out-of-range accesses

Behaviour:
- Reset values: all outputs 0, rd_streak=0, FSM=ARB, all pipeline valid bits cleared. Reset mid-operation discards in-flight reads; rd_valid drops to 0 immediately.
- At most one grant per cycle; rd_gnt and wr_ready are never both 1.
- Arbitration in ARB:
  - If rd_req is high and (wr_valid is low or rd_streak<MAX_RD_STREAK), grant the read.
  - Otherwise, if wr_valid is high, grant the write.
- rd_streak:
  - Increments on each read grant while wr_valid is high.
  - Clears on any write grant, or on any cycle with wr_valid low.
- Address: y*LCD_W+x, computed in the grant cycle and registered onto ram_addr in cycle G+1.
- Timing:
  - Grant cycle G → ram_en/ram_we/ram_addr/ram_wdata at G+1.
  - ram_rdata arrives at G+2 and is registered.
  - rd_valid=1 and rd_data presented at G+3. The read latency is fixed at 3 and a new read may be granted every cycle (fully pipelined).
- Out-of-range access (x>=LCD_W or y>=LCD_H):
  - Still granted, but ram_en stays 0 at G+1.
  - A read still produces rd_valid at G+3 with rd_data=16'h0000.
  - drop_cnt increments by 1, saturating at 16'hFFFF.
- No grants means ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their previous values.

Optional Feature:
- Macro: LCD_FB_CLEAR_EN.
- With the macro defined, add three ports: clear_start in 1, clear_color in 16, clear_busy out 1 (reset 0), plus FSM state CLEAR.
- Entering CLEAR:
  - A clear_start pulse in ARB is sampled; normal arbitration still happens in that cycle.
  - The next cycle the FSM enters CLEAR and clear_busy=1.
  - clear_color is latched when clear_start is sampled.
- Inside CLEAR:
  - wr_ready is forced to 0.
  - The internal clear writer takes the write slot under the same read-priority and streak rules, with pending always 1.
  - It writes the latched colour to addresses 0..LCD_W*LCD_H-1 in ascending order.
- Leaving CLEAR: after the last clear write is issued, the FSM returns to ARB and clear_busy=0 on the next cycle.
- clear_start while already in CLEAR is ignored.
- Without the macro: no clear ports and no CLEAR state.

Test Plan:
1. Idle, write x=3,y=2,data=F800 → wr_ready=1 same cycle; next cycle ram_en=1, ram_we=1, ram_addr=267, ram_wdata=F800.
2. Read x=131,y=161 with RAM model returning 1234 → ram_addr=21383 at G+1; rd_valid=1, rd_data=1234 at G+3.
3. rd_req held high and wr_valid held high → grant pattern R,R,R,R,W repeating; 4 consecutive reads then the write. Back-to-back reads produce consecutive rd_valid pulses.
4. Write x=132,y=0, then read x=0,y=162 → both granted, ram_en stays 0; read returns rd_valid with rd_data=0000; drop_cnt goes 0→2.
5. (LCD_FB_CLEAR_EN) clear_start, clear_color=07E0, no reads → 21384 writes to addresses 0..21383 with data 07E0; clear_busy high throughout; wr_ready=0 while wr_valid=1; normal operation resumes afterwards.
6. Assert rst_in one cycle after a read grant → rd_valid stays 0, all outputs 0 asynchronously. After release, the first read has latency 3 again.
